// File: rtl/spi_sd_pkg.sv
// Shared definitions for the SD-card SPI master: register offsets,
// STATUS/CTRL bit positions and the shift-engine state encoding.
package spi_sd_pkg;

    // Register offsets within the 0x5010-0x501F window (rs field)
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    // STATUS read bit positions
    localparam int ST_DONE = 7;
    localparam int ST_BUSY = 6;
    localparam int ST_OVR  = 5;
    localparam int ST_IE   = 1;
    localparam int ST_SS   = 0;

    // CTRL write bit positions
    localparam int CTRL_SS      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_OVR_CLR = 2;

    // DATA register value before any transfer has completed
    localparam logic [7:0] DATA_RESET = 8'hFF;

    // Shift engine phases: LOW drives MOSI, HIGH samples MISO
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sd_ctrl_if.sv
// CPU-side bus of the SD SPI master. The read-data signal is called dout
// because "do" is a reserved word in SystemVerilog.
interface spi_sd_ctrl_if;
    logic       cs;
    logic       we;
    logic [1:0] rs;
    logic [7:0] di;
    logic [7:0] dout;
    logic       irq_n;

    // CPU / address-decoder side
    modport master (output cs, we, rs, di, input dout, irq_n);
    // Peripheral side
    modport slave  (input cs, we, rs, di, output dout, irq_n);
endinterface

// File: rtl/spi_sd_clkgen.sv
// Phase timer for the SPI shift engine: a down-counter that is reloaded on
// every phase entry and flags the last cycle of the phase with tick.
module spi_sd_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reload,
    input  logic [DIV_W-1:0] load_val,
    output logic             tick
);
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Reload has priority; otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);
endmodule

// File: rtl/spi_sd_ctrl.sv
// Memory-mapped SPI mode-0 master for the SD card slot.
// Optional feature macro: SPI_SD_IRQ_EN (IE bit and irq_n output); when it is
// not defined irq_n is tied high and IE reads as 0.
// An accepted DATA write is latched at edge N (start_q) and the first LOW
// phase begins at edge N+1; during that one-cycle gap further DATA writes are
// already treated as overruns.
module spi_sd_ctrl
    import spi_sd_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 0
) (
    input  logic               clk,
    input  logic               reset,
    spi_sd_ctrl_if.slave       bus,
    output logic               sd_clk,
    output logic               sd_mosi,
    input  logic               sd_miso,
    output logic               sd_cs_n
);
    spi_state_e       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_act_q, div_act_d;
    logic [2:0]       bit_q, bit_d;
    logic             start_q, start_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             ss_q, ss_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             ie_bit;

    logic             wr_data, rd_data, wr_ctrl, wr_div;
    logic             busy, accept, complete;
    logic             tick, reload;
    logic [DIV_W-1:0] load_val;
    logic [7:0]       status;
    logic [7:0]       rdata;

    assign wr_data = bus.cs &  bus.we & (bus.rs == REG_DATA);
    assign rd_data = bus.cs & ~bus.we & (bus.rs == REG_DATA);
    assign wr_ctrl = bus.cs &  bus.we & (bus.rs == REG_CTRL);
    assign wr_div  = bus.cs &  bus.we & (bus.rs == REG_DIV);

    assign busy   = (state_q != IDLE);
    assign accept = wr_data & ~busy & ~start_q;

    // Phase timer restarts on every state entry; the first LOW uses the fresh DIV
    assign reload   = start_q | (busy & tick);
    assign load_val = start_q ? div_q : div_act_q;

    spi_sd_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .reload   (reload),
        .load_val (load_val),
        .tick     (tick)
    );

    // Shift engine sequencing plus register-file updates from the CPU bus
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        data_d    = data_q;
        div_d     = div_q;
        div_act_d = div_act_q;
        bit_d     = bit_q;
        start_d   = 1'b0;
        done_d    = done_q;
        ovr_d     = ovr_q;
        ss_d      = ss_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_q) begin
                    state_d   = LOW;
                    div_act_d = div_q;
                    bit_d     = '0;
                    sclk_d    = 1'b0;
                    mosi_d    = shift_q[7];
                end
            end
            LOW: begin
                if (tick) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[6:0], sd_miso};
                end
            end
            HIGH: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d  = IDLE;
                        mosi_d   = 1'b1;
                        data_d   = shift_q;
                        complete = 1'b1;
                    end else begin
                        state_d = LOW;
                        mosi_d  = shift_q[7];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            shift_d = bus.di;
            start_d = 1'b1;
            done_d  = 1'b0;
        end else if (wr_data) begin
            ovr_d = 1'b1;
        end

        // Completion is applied last so it beats a same-edge DATA read
        if (rd_data) begin
            done_d = 1'b0;
        end
        if (complete) begin
            done_d = 1'b1;
        end

        if (wr_ctrl) begin
            ss_d = bus.di[CTRL_SS];
            if (bus.di[CTRL_OVR_CLR]) begin
                ovr_d = 1'b0;
            end
        end
        if (wr_div) begin
            div_d = DIV_W'(bus.di);
        end
    end

    // Main state and register-file flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            data_q    <= DATA_RESET;
            div_q     <= DIV_W'(DIV_RESET);
            div_act_q <= DIV_W'(DIV_RESET);
            bit_q     <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            ss_q      <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            div_q     <= div_d;
            div_act_q <= div_act_d;
            bit_q     <= bit_d;
            start_q   <= start_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            ss_q      <= ss_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

`ifdef SPI_SD_IRQ_EN
    logic ie_q, ie_d;
    logic irq_q, irq_d;

    // Interrupt enable and registered interrupt, computed from next-state DONE
    always_comb begin
        ie_d = ie_q;
        if (wr_ctrl) begin
            ie_d = bus.di[CTRL_IE];
        end
        irq_d = ~(done_d & ie_d);
    end

    // Interrupt flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b1;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign ie_bit    = ie_q;
    assign bus.irq_n = irq_q;
`else
    assign ie_bit    = 1'b0;
    assign bus.irq_n = 1'b1;
`endif

    // STATUS assembly and read mux; reads are 0x00 when not selected
    always_comb begin
        status          = '0;
        status[ST_DONE] = done_q;
        status[ST_BUSY] = busy;
        status[ST_OVR]  = ovr_q;
        status[ST_IE]   = ie_bit;
        status[ST_SS]   = ss_q;
        rdata           = 8'h00;
        if (bus.cs) begin
            case (bus.rs)
                REG_DATA: rdata = data_q;
                REG_CTRL: rdata = status;
                REG_DIV:  rdata = 8'(div_q);
                default:  rdata = 8'h00;
            endcase
        end
    end

    assign bus.dout = rdata;
    assign sd_clk   = sclk_q;
    assign sd_mosi  = mosi_q;
    assign sd_cs_n  = ~ss_q;
endmodule

// File: tb/tb_spi_sd_ctrl.sv
// Self-checking bench for spi_sd_ctrl: expected received bytes are queued
// when a transfer is launched and compared when the DUT reports DONE.
`timescale 1ns/1ps
module tb_spi_sd_ctrl;
    import spi_sd_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sd_clk, sd_mosi, sd_miso, sd_cs_n;
    logic loop_en  = 1'b0;
    logic miso_drv = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

`ifdef SPI_SD_IRQ_EN
    localparam logic [7:0] IE_ST   = 8'h02;
    localparam logic       IRQ_DONE = 1'b0;
`else
    localparam logic [7:0] IE_ST   = 8'h00;
    localparam logic       IRQ_DONE = 1'b1;
`endif

    spi_sd_ctrl_if bus();

    spi_sd_ctrl #(.DIV_W(8), .DIV_RESET(0)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .sd_clk  (sd_clk),
        .sd_mosi (sd_mosi),
        .sd_miso (sd_miso),
        .sd_cs_n (sd_cs_n)
    );

    assign sd_miso = loop_en ? sd_mosi : miso_drv;

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.cs = 1'b0; bus.we = 1'b0; bus.rs = 2'd0; bus.di = 8'h00;
    endtask

    task automatic wr(input logic [1:0] r, input logic [7:0] d);
        bus.cs = 1'b1; bus.we = 1'b1; bus.rs = r; bus.di = d;
        tick();
        bus_idle();
    endtask

    task automatic rd(input logic [1:0] r, output logic [7:0] d);
        bus.cs = 1'b1; bus.we = 1'b0; bus.rs = r;
        #1 d = bus.dout;
        tick();
        bus_idle();
    endtask

    // Polls STATUS each cycle until BUSY drops; measures phases and MOSI bits
    task automatic xfer_mon(input int div, input logic [7:0] pat, input bit partial,
                            output int busy_cyc, output logic [7:0] mosi_bits,
                            output int bad_half, output int nbits,
                            output logic [7:0] st_done, output logic irq_done);
        logic prev_clk;
        int   run;
        int   idx;
        bit   first;
        bit   seen;
        prev_clk = 1'b0; run = 0; idx = 7; first = partial; seen = 1'b0;
        busy_cyc = 0; mosi_bits = 8'h00; bad_half = 0; nbits = 0;
        st_done = 8'h00; irq_done = 1'b1;
        miso_drv = pat[7];
        bus.cs = 1'b1; bus.we = 1'b0; bus.rs = REG_CTRL;
        for (int k = 0; k < 4000; k++) begin
            tick();
            if (!bus.dout[ST_BUSY]) begin
                seen     = 1'b1;
                st_done  = bus.dout;
                irq_done = bus.irq_n;
                if (run != div + 1) bad_half++;
                break;
            end
            busy_cyc++;
            if (sd_clk != prev_clk) begin
                if (!first && run != div + 1) bad_half++;
                first = 1'b0;
                if (sd_clk) begin
                    mosi_bits = {mosi_bits[6:0], sd_mosi};
                    nbits++;
                    idx--;
                    if (idx >= 0) miso_drv = pat[idx];
                end
                run = 1;
            end else begin
                run++;
            end
            prev_clk = sd_clk;
        end
        bus_idle();
        check("xfer_complete", seen, 1'b1);
    endtask

    // Scoreboard pop: read DATA and compare with the oldest queued byte
    task automatic pop_check(input string tag);
        logic [7:0] got;
        rd(REG_DATA, got);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            check({tag, "_rx"}, got, exp_q.pop_front());
        end
        check({tag, "_irq_after_rd"}, bus.irq_n, 1'b1);
        $display("xfer %s rx=%02h", tag, got);
    endtask

    task automatic run_case(input string tag, input int div, input logic [7:0] tx,
                            input bit loop, input logic [7:0] pat,
                            input logic [7:0] exp_st);
        int         busy_cyc, bad_half, nbits;
        logic [7:0] mosi_bits, st_done;
        logic       irq_done;
        wr(REG_DIV, div[7:0]);
        loop_en = loop;
        exp_q.push_back(loop ? tx : pat);
        wr(REG_DATA, tx);
        xfer_mon(div, pat, 1'b0, busy_cyc, mosi_bits, bad_half, nbits, st_done, irq_done);
        check({tag, "_busy_cycles"}, busy_cyc, 16 * (div + 1));
        check({tag, "_mosi"}, mosi_bits, tx);
        check({tag, "_nbits"}, nbits, 8);
        check({tag, "_half_period"}, bad_half, 0);
        check({tag, "_status_done"}, st_done, exp_st);
        check({tag, "_irq_done"}, irq_done, (exp_st & IE_ST) != 0 ? IRQ_DONE : 1'b1);
        $display("xfer %s tx=%02h div=%0d busy=%0d mosi=%02h", tag, tx, div, busy_cyc, mosi_bits);
        pop_check(tag);
    endtask

    initial begin
        logic [7:0] v;
        int         busy_cyc, bad_half, nbits;
        logic [7:0] mosi_bits, st_done;
        logic       irq_done;

        bus_idle();
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        tick();

        // Reset state
        check("rst_cs_n", sd_cs_n, 1'b1);
        check("rst_sclk", sd_clk, 1'b0);
        check("rst_mosi", sd_mosi, 1'b1);
        check("rst_irq", bus.irq_n, 1'b1);
        rd(REG_CTRL, v); check("rst_status", v, 8'h00);
        rd(REG_DATA, v); check("rst_data", v, 8'hFF);
        rd(REG_DIV, v);  check("rst_div", v, 8'h00);

        // Reset asserted mid-transfer (during a HIGH phase, MOSI=0)
        wr(REG_CTRL, 8'h01);
        wr(REG_DIV, 8'd3);
        wr(REG_DATA, 8'h5A);
        repeat (6) tick();
        check("mid_sclk_high", sd_clk, 1'b1);
        check("mid_cs_n", sd_cs_n, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("arst_cs_n", sd_cs_n, 1'b1);
        check("arst_sclk", sd_clk, 1'b0);
        check("arst_mosi", sd_mosi, 1'b1);
        check("arst_irq", bus.irq_n, 1'b1);
        bus.cs = 1'b1; bus.we = 1'b0; bus.rs = REG_CTRL;
        #1 check("arst_status", bus.dout, 8'h00);
        bus_idle();
        @(negedge clk) reset = 1'b0;
        tick();
        rd(REG_DATA, v); check("arst_data", v, 8'hFF);
        rd(REG_DIV, v);  check("arst_div", v, 8'h00);
        $display("xfer reset_mid tx=5a aborted");

        // Loopback at DIV=0, then divider with an independent MISO pattern
        wr(REG_CTRL, 8'h01);
        run_case("loop", 0, 8'hA5, 1'b1, 8'h00, 8'h81);
        run_case("div4", 4, 8'h3C, 1'b0, 8'h96, 8'h81);

        // Overrun: second write two cycles after the first is ignored
        wr(REG_DIV, 8'd3);
        loop_en = 1'b1;
        exp_q.push_back(8'h11);
        wr(REG_DATA, 8'h11);
        tick();
        wr(REG_DATA, 8'h22);
        rd(REG_CTRL, v); check("ovr_status_busy", v, 8'h61);
        xfer_mon(3, 8'h00, 1'b1, busy_cyc, mosi_bits, bad_half, nbits, st_done, irq_done);
        check("ovr_mosi", mosi_bits, 8'h11);
        check("ovr_half_period", bad_half, 0);
        check("ovr_status_done", st_done, 8'hA1);
        $display("xfer ovr tx=11 mosi=%02h", mosi_bits);
        pop_check("ovr");
        wr(REG_CTRL, 8'h05);
        rd(REG_CTRL, v); check("ovr_cleared", v, 8'h01);

        // DIV written mid-transfer is held until the next start
        wr(REG_DIV, 8'd1);
        exp_q.push_back(8'h69);
        wr(REG_DATA, 8'h69);
        wr(REG_DIV, 8'd5);
        xfer_mon(1, 8'h00, 1'b1, busy_cyc, mosi_bits, bad_half, nbits, st_done, irq_done);
        check("divhold_half_period", bad_half, 0);
        check("divhold_mosi", mosi_bits, 8'h69);
        $display("xfer divhold tx=69 mosi=%02h", mosi_bits);
        pop_check("divhold");
        rd(REG_DIV, v); check("divhold_div_reg", v, 8'd5);

        // Interrupt enable (ignored when the feature is not built)
        wr(REG_CTRL, 8'h03);
        rd(REG_CTRL, v); check("ie_status", v, 8'h01 | IE_ST);
        run_case("irq", 0, 8'h5B, 1'b1, 8'h00, 8'h81 | IE_ST);

        // Race: DATA read on the completion edge keeps DONE and sees new byte
        wr(REG_DIV, 8'd0);
        loop_en = 1'b1;
        exp_q.push_back(8'hC3);
        wr(REG_DATA, 8'hC3);
        repeat (16) tick();
        bus.cs = 1'b1; bus.we = 1'b0; bus.rs = REG_DATA;
        tick();
        v = bus.dout;
        bus_idle();
        if (exp_q.size() == 0) check("race_sb_empty", 1, 0);
        else check("race_rx", v, exp_q.pop_front());
        check("race_irq", bus.irq_n, IRQ_DONE);
        rd(REG_CTRL, v); check("race_status", v, 8'h81 | IE_ST);
        $display("xfer race tx=c3 rx=%02h", v);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_sd_ctrl.md
# spi_sd_ctrl

Memory-mapped SPI master that sequences the SD-card pins (sdClk, sdMosi, sdCs, sdMiso) in hardware so the 65C02 no longer bit-bangs them through VIA port A. It sits on the CPU bus beside the VIA and ACIA, is decoded at 0x5010–0x501F, and runs from the divided CPU clock. The CPU writes a byte, the block shifts it out in SPI mode 0 while shifting a byte in, then it flags completion by status bit and optional interrupt.

## Interface
- DIV_W, 8: width of the SCLK divider register.
- DIV_RESET, 0: reset value of DIV; half-bit period = (DIV+1) clk cycles.
- clk  in  1  CPU clock (divided system clock); all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cs  in  1  chip select from the address decoder (registered address).
- we  in  1  1 = CPU write, 0 = CPU read.
- rs  in  2  register select: 0 DATA, 1 CTRL/STATUS, 2 DIV, 3 reserved.
- di  in  8  CPU write data.
- do  out  8  read data, combinational from rs; reads 0x00 when cs=0.
- irq_n  out  1  active-low interrupt to the CPU IRQ OR.
- sd_clk  out  1  SPI clock, idle low.
- sd_mosi  out  1  SPI data out, MSB first, idle high.
- sd_miso  in  1  SPI data in, sampled on SCLK rising edge.
- sd_cs_n  out  1  card select, direct from CTRL.SS.

## Operation
- DATA write (cs=1, we=1, rs=0) while idle: load shift register, set BUSY, clear DONE.
- DATA write while BUSY: ignored, sets OVR (sticky).
- DATA read: returns last received byte; the clk edge with cs=1, we=0, rs=0 clears DONE.
- CTRL write: bit0 SS (1 drives sd_cs_n=0), bit1 IE, bit2 writing 1 clears OVR.
- STATUS read: bit7 DONE, bit6 BUSY, bit5 OVR, bit1 IE, bit0 SS, others 0.
- DIV write: takes effect at the next transfer start; a write during BUSY is held until then.
- FSM states: IDLE, LOW, HIGH.
  - IDLE -> LOW on accepted DATA write.
  - LOW: sd_clk=0, sd_mosi = shift[7], holds DIV+1 cycles, then -> HIGH.
  - Entering HIGH: sd_clk=1, sd_miso is shifted into bit0 and shift is shifted left. Holds DIV+1 cycles. After the 8th bit -> IDLE, else -> LOW.
- Bit counter is 3 bits and wraps after bit 7. The divider counter reloads on every state entry.
- Completion vs a DATA read on the same edge: completion wins, so DONE stays 1.
- Completion vs a CTRL OVR-clear on the same edge: both take effect.
- SS changes are immediate. Dropping SS mid-transfer does not abort the transfer.

## Timing
- Reset values: sd_clk=0, sd_mosi=1, sd_cs_n=1, irq_n=1, DATA=0xFF, DIV=DIV_RESET, DONE/BUSY/OVR/IE/SS=0, state IDLE.
- Accepted DATA write at edge N: BUSY=1 and first LOW phase begin at N+1.
- Full transfer = 16×(DIV+1) cycles. BUSY clears, DONE sets and rx byte is visible at edge N+1+16×(DIV+1).
- irq_n = ~(DONE & IE). It is registered and follows DONE by 0 cycles.
- Reset asserted mid-transfer: everything returns to reset values immediately and asynchronously, and the partial rx byte is discarded.

## Configuration
- SPI_SD_IRQ_EN defined: IE bit and irq_n behave as above.
- SPI_SD_IRQ_EN undefined: irq_n is constant 1, IE is not implemented and reads 0, and CTRL bit1 writes are ignored. Firmware must poll STATUS.

## Structure
- Package spi_sd_pkg holds:
  - register offsets REG_DATA, REG_CTRL, REG_DIV;
  - STATUS/CTRL bit-position constants;
  - FSM state enum (IDLE, LOW, HIGH).
- Sub-module spi_sd_clkgen: DIV_W-bit down-counter with reload input and phase-end tick output, reused by each FSM phase.

## Test plan
- Reset: assert mid-transfer with DIV=3 -> next cycle sd_cs_n=1, sd_clk=0, sd_mosi=1, STATUS=0x00, DATA read 0xFF.
- Loopback: DIV=0, tie sd_miso=sd_mosi, write 0xA5 -> BUSY for exactly 16 cycles, MOSI bits 1,0,1,0,0,1,0,1, DATA reads 0xA5, DONE=1.
- Divider: DIV=4, write 0x3C -> each sd_clk half-period is 5 cycles, completion after 80 cycles.
- Overrun: write 0x11 then 0x22 two cycles later -> second write ignored, OVR=1, transfer sends 0x11. CTRL write 0x04 -> OVR=0.
- Interrupt (SPI_SD_IRQ_EN): IE=1, transfer completes -> irq_n=0. Read DATA -> irq_n=1 the next cycle. With the macro undefined, irq_n stays 1 throughout.
- Race: DATA read on the completion edge -> DONE remains 1 and the returned value is the new byte.
